// File: rtl/uart_transmitter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_transmitter                                             |
// | Description : Byte-wide UART transmitter with a one-entry holding register |
// |               in front of the shifter, so back-to-back frames leave with   |
// |               no idle gap. Frames are 8N1/8N2 by default.                  |
// |               Define UART_TX_PARITY_EN to add an even-parity bit (8E1/8E2).|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 104,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_tx,
  output logic       busy
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic             stop_idx;
  logic [7:0]       shifter;
  logic [7:0]       hold_data;
  logic             hold_full;
`ifdef UART_TX_PARITY_EN
  logic             parity;
`endif

  logic accept;
  logic bit_end;
  logic stop_end;
  logic load;

  assign accept   = tx_valid & tx_ready;
  assign bit_end  = (cnt == CNT_LAST);
  assign stop_end = bit_end & (stop_idx == STOP_LAST);
  // The shifter takes the held byte either from idle or on the last stop cycle,
  // which is what gives zero-gap back-to-back frames.
  assign load     = hold_full & ((state == S_IDLE) | ((state == S_STOP) & stop_end));
  assign busy     = (state != S_IDLE) | hold_full;

  // Holding register, baud counter and frame FSM; uart_tx is always a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      stop_idx  <= 1'b0;
      shifter   <= 8'h00;
      hold_data <= 8'h00;
      hold_full <= 1'b0;
      tx_ready  <= 1'b1;
      uart_tx   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      // A load needs hold_full=1, so tx_ready is already low and no accept
      // can coincide with it; ready comes back the following cycle.
      if (load) begin
        hold_full <= 1'b0;
        tx_ready  <= 1'b1;
      end else if (accept) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
        tx_ready  <= 1'b0;
      end

      if (load) begin
        shifter <= hold_data;
`ifdef UART_TX_PARITY_EN
        parity  <= ^hold_data;
`endif
      end

      cnt <= bit_end ? '0 : cnt + 1'b1;

      case (state)
        S_IDLE: begin
          cnt     <= '0;
          uart_tx <= 1'b1;
          if (hold_full) begin
            uart_tx <= 1'b0;
            state   <= S_START;
          end
        end

        S_START: begin
          if (bit_end) begin
            uart_tx <= shifter[0];
            shifter <= {1'b0, shifter[7:1]};
            bit_idx <= 3'd0;
            state   <= S_DATA;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              uart_tx  <= parity;
              state    <= S_PARITY;
`else
              uart_tx  <= 1'b1;
              stop_idx <= 1'b0;
              state    <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              uart_tx <= shifter[0];
              shifter <= {1'b0, shifter[7:1]};
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            uart_tx  <= 1'b1;
            stop_idx <= 1'b0;
            state    <= S_STOP;
          end
        end
`endif

        S_STOP: begin
          if (stop_end) begin
            if (hold_full) begin
              uart_tx <= 1'b0;
              state   <= S_START;
            end else begin
              state   <= S_IDLE;
            end
          end else if (bit_end) begin
            stop_idx <= stop_idx + 1'b1;
          end
        end

        default: begin
          state   <= S_IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_transmitter                                          |
// | Description : Scoreboard bench for uart_transmitter. Stimulus pushes the   |
// |               bytes it sends; a line monitor decodes frames on uart_tx and |
// |               pops/compares. A second instance covers STOP_BITS=2.         |
// |               Honours UART_TX_PARITY_EN like the design.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_transmitter;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME  = (1 + 8 + P + 1) * C;
  localparam int FRAME2 = (1 + 8 + P + 2) * C;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, uart_tx, busy;
  logic [7:0] tx_data2 = 8'h00;
  logic       tx_valid2 = 1'b0;
  logic       tx_ready2, uart_tx2, busy2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];
  logic       last_par = 1'b0;

  uart_transmitter #(.CLKS_PER_BIT(C), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .uart_tx(uart_tx), .busy(busy));

  uart_transmitter #(.CLKS_PER_BIT(C), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .uart_tx(uart_tx2), .busy(busy2));

  always #5 clk = ~clk;

  // Edge counter: read right after a posedge it gives that edge's index.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, output int hs);
    tx_data  = b;
    tx_valid = 1'b1;
    exp_q.push_back(b);
    hs = -1;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      if (tx_ready) begin
        hs = cyc;
        break;
      end
    end
    #1;
    tx_valid = 1'b0;
    if (hs < 0) check_eq("handshake timeout", hs, 0);
  endtask

  task automatic wait_idle(output int e);
    e = -1;
    for (int n = 0; n < 1000; n++) begin
      @(posedge clk);
      #1;
      if (!busy) begin
        e = cyc - 1;
        break;
      end
    end
    if (e < 0) check_eq("idle timeout", e, 0);
  endtask

  // Samples n cycles of the line; value is the first sample, stable flags any change.
  task automatic get_bit(input int n, output logic v, output bit stable, output bit abort);
    v = 1'bx;
    stable = 1'b1;
    abort = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (reset) begin
        abort = 1'b1;
        return;
      end
      if (i == 0) v = uart_tx;
      else if (uart_tx !== v) stable = 1'b0;
    end
  endtask

  task automatic rx_frame();
    logic v, p;
    bit st, ab, ok;
    logic [7:0] d, e;
    p = 1'b0;
    d = 8'h00;
    get_bit(C - 1, v, st, ab);
    if (ab) return;
    ok = st && (v === 1'b0);
    for (int b = 0; b < 8; b++) begin
      get_bit(C, v, st, ab);
      if (ab) return;
      d[b] = v;
      ok = ok && st;
    end
`ifdef UART_TX_PARITY_EN
    get_bit(C, v, st, ab);
    if (ab) return;
    p = v;
    last_par = v;
    ok = ok && st;
`endif
    get_bit(C, v, st, ab);
    if (ab) return;
    ok = ok && st && (v === 1'b1);
    check_eq("frame start/stop/bit width", int'(ok), 1);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected frame: got byte %0d expected no frame", d);
    end else begin
      e = exp_q.pop_front();
      check_eq("rx byte", d, e);
      if (P == 1) check_eq("rx parity", p, ^e);
    end
  endtask

  // Line monitor: detects start bits on uart_tx and checks decoded frames.
  initial begin
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b1;
      end else if (prev && !uart_tx) begin
        start_q.push_back(cyc - 1);
        rx_frame();
        prev = 1'b1;
      end else begin
        prev = uart_tx;
      end
    end
  end

  // Stimulus: directed tests, all with hand-derived timing.
  initial begin
    int n1, n2, n3, idle, gap, pos;
    logic ev;
    logic [7:0] d2;
    bit quiet;

    repeat (3) @(posedge clk);
    #1;
    check_eq("reset uart_tx", uart_tx, 1);
    check_eq("reset tx_ready", tx_ready, 1);
    check_eq("reset busy", busy, 0);
    check_eq("reset uart_tx2", uart_tx2, 1);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single byte 0x55
    start_q.delete();
    send(8'h55, n1);
    check_eq("hs edge tx_ready", tx_ready, 0);
    check_eq("hs edge busy", busy, 1);
    @(posedge clk);
    #1;
    check_eq("start bit after 1 cycle", uart_tx, 0);
    check_eq("tx_ready back at start", tx_ready, 1);
    wait_idle(idle);
    check_eq("single frame length", idle - (n1 + 1), FRAME);
    check_eq("single start edge", (start_q.size() > 0) ? start_q[0] : -1, n1 + 1);

    // Back-to-back 0xA5, 0x3C
    repeat (3) @(posedge clk);
    #1;
    start_q.delete();
    send(8'hA5, n1);
    send(8'h3C, n2);
    check_eq("b2b second handshake", n2, n1 + 2);
    wait_idle(idle);
    check_eq("b2b total length", idle - (n1 + 1), 2 * FRAME);
    gap = (start_q.size() == 2) ? start_q[1] - start_q[0] : -1;
    check_eq("b2b start spacing", gap, FRAME);

    // Backpressure 0x01, 0x02, 0x03
    repeat (3) @(posedge clk);
    #1;
    start_q.delete();
    send(8'h01, n1);
    send(8'h02, n2);
    check_eq("bp ready low while held", tx_ready, 0);
    check_eq("bp second accept", n2, n1 + 2);
    send(8'h03, n3);
    check_eq("bp third accept after load", n3, n1 + FRAME + 2);
    wait_idle(idle);
    check_eq("bp total length", idle - (n1 + 1), 3 * FRAME);

`ifdef UART_TX_PARITY_EN
    // Parity 0x07 -> 1, 0x03 -> 0
    repeat (3) @(posedge clk);
    #1;
    send(8'h07, n1);
    wait_idle(idle);
    check_eq("parity of 0x07", last_par, 1);
    check_eq("parity frame length", idle - (n1 + 1), 44);
    send(8'h03, n1);
    wait_idle(idle);
    check_eq("parity of 0x03", last_par, 0);
`endif

    // STOP_BITS=2 instance, 0xFF
    d2 = 8'hFF;
    tx_data2  = d2;
    tx_valid2 = 1'b1;
    n1 = -1;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      if (tx_ready2) begin
        n1 = cyc;
        break;
      end
    end
    #1;
    tx_valid2 = 1'b0;
    check_eq("stop2 handshake", int'(n1 >= 0), 1);
    for (int k = 1; k <= FRAME2; k++) begin
      @(posedge clk);
      #1;
      pos = (k - 1) / C;
      if (pos == 0) ev = 1'b0;
      else if (pos <= 8) ev = d2[pos-1];
      else if (P == 1 && pos == 9) ev = ^d2;
      else ev = 1'b1;
      check_eq("stop2 line", uart_tx2, ev);
      if (k == FRAME2) check_eq("stop2 busy last cycle", busy2, 1);
    end
    @(posedge clk);
    #1;
    check_eq("stop2 idle after frame", busy2, 0);

    // Reset during data bit 3 of 0x00 with 0x81 queued
    repeat (3) @(posedge clk);
    #1;
    send(8'h00, n1);
    send(8'h81, n2);
    repeat (16) @(posedge clk);
    #1;
    check_eq("mid data bit 3 line", uart_tx, 0);
    check_eq("second byte held", tx_ready, 0);
    #1;
    reset = 1'b1;
    #1;
    check_eq("async reset uart_tx", uart_tx, 1);
    check_eq("async reset tx_ready", tx_ready, 1);
    check_eq("async reset busy", busy, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      if (uart_tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
    end
    check_eq("no frame after reset release", int'(quiet), 1);

    send(8'hC3, n1);
    wait_idle(idle);
    check_eq("post-reset frame length", idle - (n1 + 1), FRAME);

    repeat (4) @(posedge clk);
    check_eq("scoreboard drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_transmitter.md
# uart_transmitter

Byte-oriented UART transmitter: it accepts 8-bit words over a valid/ready handshake and serialises them as 8N1 frames, or 8E1 with parity compiled in, at a parameterised bit period.
- It has a one-entry holding register, so a source can queue the next byte while the current frame is on the wire. Back-to-back frames then go out with no idle gap.
- It is the transmit-side companion of the board's UART receive path, driving the serial TX pin from the fabric clock domain.

## Interface
Parameters:
- CLKS_PER_BIT, 104, clk cycles per serial bit (12 MHz / 115200); legal range 2..65535
- STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- tx_data  in  8  byte to send, LSB transmitted first; must be stable while tx_valid=1
- tx_valid  in  1  source has a byte on tx_data
- tx_ready  out  1  holding register empty; transfer occurs on a rising edge where tx_valid & tx_ready
- uart_tx  out  1  serial line, idle high
- busy  out  1  frame in progress or byte held

## Operation
- Holding register (hold_data, hold_full):
  - set on handshake;
  - cleared when the FSM loads the shifter.
  - tx_ready = ~hold_full, registered.
- FSM states and transitions:
  - IDLE: uart_tx=1. If hold_full: load shifter from hold, clear hold_full, uart_tx<=0, go to START.
  - START: hold uart_tx=0 for CLKS_PER_BIT cycles, then output shifter[0] and go to DATA.
  - DATA: 8 bits, each CLKS_PER_BIT cycles, LSB first. The bit index runs 0..7. After bit 7, go to PARITY if configured, else STOP.
  - PARITY (only with macro): XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles, then STOP.
  - STOP: uart_tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the final cycle:
    - if hold_full: load the next byte and go directly to START (uart_tx<=0);
    - else go to IDLE.
- Baud counter:
  - width $clog2(CLKS_PER_BIT);
  - counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary;
  - resets to 0 on every state entry.
- Load and accept in the same cycle: if the shifter loads from hold while tx_valid=1 and tx_ready=0, no new accept occurs that cycle; tx_ready rises the next cycle.
- busy = (state != IDLE) | hold_full.
- uart_tx is driven from a flop (no combinational glitches on the pin).

## Timing
- Reset values: uart_tx=1, tx_ready=1, busy=0, state=IDLE, hold_full=0, counters 0.
- Reset mid-frame: line returns high asynchronously, queued byte is discarded, no partial frame resumes after release.
- Latency, from a handshake at edge N with the FSM in IDLE:
  - edge N: hold_full=1, tx_ready=0;
  - edge N+1: uart_tx falls (start bit), tx_ready=1.
- Frame length: (1 + 8 + P + STOP_BITS) * CLKS_PER_BIT cycles, where P=1 with parity, else 0.
- Back-to-back: the next start bit begins on the edge immediately after the last stop-bit cycle. Zero idle cycles.
- Throughput: one byte per frame length.
- A handshake during a frame is accepted when hold is empty. Further tx_valid stalls (tx_ready=0) until the shifter loads.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state is compiled in; frames are 8E1 (or 8E2).
- UART_TX_PARITY_EN undefined: PARITY state and its parity flop are absent; frames are 8N1 (or 8N2).

## Test plan
- Single byte, CLKS_PER_BIT=4, STOP_BITS=1, no parity:
  - stimulus: send 0x55;
  - required: uart_tx reads 0,1,0,1,0,1,0,1,0,1, each held 4 cycles. Start bit begins 1 cycle after the handshake, frame is 40 cycles, then busy=0.
- Back-to-back:
  - stimulus: hold tx_valid high with 0xA5 then 0x3C;
  - required: second handshake completes one cycle after the first start bit. The second start bit follows the first stop bit with no idle cycle. Total 80 cycles high-to-idle.
- Backpressure:
  - stimulus: present 3 bytes (0x01, 0x02, 0x03) continuously;
  - required: tx_ready=0 while hold_full, and every byte appears exactly once, in order.
- Parity (macro defined):
  - stimulus: send 0x07, then 0x03;
  - required: parity bit is 1 for 0x07 and 0 for 0x03. Frame is 44 cycles at CLKS_PER_BIT=4.
- STOP_BITS=2:
  - stimulus: send 0xFF;
  - required: line high for 8 stop cycles after the data bits; frame is 44 cycles.
- Reset mid-frame:
  - stimulus: assert reset during data bit 3 of 0x00 with a second byte queued;
  - required: uart_tx=1 immediately, tx_ready=1, busy=0, and no frame is emitted after release until a new handshake.
